// File: rtl/sram_like_if.sv
// Data-side SRAM-like bus between a CPU memory stage (master) and a memory
// responder (slave).
//
// Handshake semantics:
//   - Address phase: a request is accepted on a rising clock edge where
//     req && addr_ok. addr_ok is driven by the slave and never depends on req.
//     req, wr, size, addr, wstrb and wdata only need to be stable in that cycle.
//   - Data phase: data_ok is a one-cycle pulse per accepted request, in
//     acceptance order. rdata is meaningful only while data_ok is high. There
//     is no backpressure: the master must take data_ok when it is asserted.
//   - addr_stall is a test hook from the master side that forces addr_ok low.
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_stall;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata, addr_stall,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata, addr_stall,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_responder.sv
// Slave end of the SRAM-like data bus. Accepted requests are kept in a small
// circular queue; each entry counts down from LATENCY-1 and the head answers
// with a single data_ok pulse once its countdown reaches zero. Writes land in
// the local word memory on the accept edge; reads capture the memory word on
// the accept edge, so the response carries the contents as of acceptance.
module sram_like_responder #(
  parameter int LATENCY = 2,   // accept edge to data_ok, 1..15 cycles
  parameter int DEPTH   = 4,   // max outstanding requests, power of 2, >= 2
  parameter int AW      = 10   // word-address width
) (
  input  logic                     clk,
  input  logic                     reset,
  sram_like_if.slave               bus,
  output logic [$clog2(DEPTH):0]   dbg_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = 4;

  // Queue state
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [TW-1:0] tmr_q [DEPTH];
  logic [TW-1:0] tmr_d [DEPTH];
  logic [31:0]   dat_q [DEPTH];
  logic [31:0]   dat_d [DEPTH];

  // Word memory, deliberately not reset
  logic [31:0] mem [2**AW];

  logic          addr_ok;
  logic          accept;
  logic          resp;
  logic [AW-1:0] widx;

  // size and the bits outside the word index carry no meaning here
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.size, bus.addr[31:AW+2], bus.addr[1:0]};

  assign widx   = bus.addr[AW+1:2];
  assign accept = bus.req && addr_ok && !reset;

  // Output decode: accept gating and head-of-queue response
  always_comb begin
    addr_ok     = (count_q < CW'(DEPTH)) && !bus.addr_stall;
    resp        = vld_q[head_q] && (tmr_q[head_q] == '0);
    bus.addr_ok = addr_ok;
    bus.data_ok = resp;
    bus.rdata   = resp ? dat_q[head_q] : 32'h0;
    dbg_count_o = count_q;
  end

  // Next-state: countdowns tick, head pops on response, tail pushes on accept
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    tmr_d   = tmr_q;
    dat_d   = dat_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (tmr_q[i] != '0)) tmr_d[i] = tmr_q[i] - TW'(1);
    end

    if (resp) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end

    // Push slot never equals the pop slot: that needs count 0 or count DEPTH
    if (accept) begin
      vld_d[tail_q] = 1'b1;
      tmr_d[tail_q] = TW'(LATENCY - 1);
      dat_d[tail_q] = bus.wr ? 32'h0 : mem[widx];
      tail_d        = tail_q + PW'(1);
    end

    case ({accept, resp})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset; discards outstanding responses
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tmr_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      tmr_q   <= tmr_d;
      dat_q   <= dat_d;
    end
  end

  // Byte-enabled write into memory on the accept edge
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder. Two responders share one stimulus stream:
// instance 0 runs LATENCY=1 (streaming), instance 1 runs LATENCY=8 so that a
// DEPTH=4 queue actually fills. The reference model is a per-instance word
// array plus an expected-response queue of {due cycle, data}.
module tb_sram_like_responder;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int CW    = 3;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 8;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        addr_stall = 1'b0;

  logic [1:0]    addr_ok_w;
  logic [1:0]    data_ok_w;
  logic [31:0]   rdata_w [2];
  logic [CW-1:0] dbg_count_w [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_like_if bus();
    assign bus.req        = req;
    assign bus.wr         = wr;
    assign bus.size       = size;
    assign bus.addr       = addr;
    assign bus.wstrb      = wstrb;
    assign bus.wdata      = wdata;
    assign bus.addr_stall = addr_stall;

    sram_like_responder #(
      .LATENCY ((g == 0) ? 1 : 8),
      .DEPTH   (DEPTH),
      .AW      (AW)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .dbg_count_o (dbg_count_w[g])
    );

    assign addr_ok_w[g] = bus.addr_ok;
    assign data_ok_w[g] = bus.data_ok;
    assign rdata_w[g]   = bus.rdata;
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [31:0] due;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q [2][$];
  logic [31:0] ref_mem [2][1 << AW];

  int n_pass  = 0;
  int n_total = 0;
  bit checking = 1'b0;
  int occ_m;

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] cycle %0d: got %h expected %h",
                  name, inst, cyc, act, exp);
  endtask

  // Monitor: every cycle, compare handshake, occupancy and response per instance
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        // entries accepted this cycle (due == cyc+LAT) do not occupy yet
        occ_m = exp_q[i].size();
        if (occ_m > 0 && exp_q[i][occ_m-1].due == cyc + 32'(lat_of(i))) occ_m--;
        check("addr_ok", i, 32'(addr_ok_w[i]), 32'((occ_m < DEPTH) && !addr_stall));
        check("count", i, 32'(dbg_count_w[i]), 32'(occ_m));
        if (exp_q[i].size() > 0 && exp_q[i][0].due == cyc) begin
          check("data_ok", i, 32'(data_ok_w[i]), 32'd1);
          check("rdata", i, rdata_w[i], exp_q[i][0].data);
          void'(exp_q[i].pop_front());
        end else begin
          check("data_ok_idle", i, 32'(data_ok_w[i]), 32'd0);
          check("rdata_idle", i, rdata_w[i], 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One bus cycle: drive inputs, predict per-instance acceptance and push the
  // expected response, then advance to just after the next rising edge.
  task automatic step(input logic r, input logic rq, input logic w,
                      input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic st,
                      output logic [1:0] acc);
    logic [AW-1:0] idx;
    logic [31:0]   rd;
    reset      = r;
    req        = rq && !r;
    wr         = w;
    addr       = a;
    wstrb      = s;
    wdata      = d;
    addr_stall = st;
    size       = 2'($urandom_range(0, 2));
    idx        = a[AW+1:2];
    acc        = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (!r && rq && !st && exp_q[i].size() < DEPTH) begin
        acc[i] = 1'b1;
        rd = w ? 32'h0 : ref_mem[i][idx];
        exp_q[i].push_back('{due: cyc + 32'(lat_of(i)), data: rd});
        if (w) begin
          for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[i][idx][8*b +: 8] = d[8*b +: 8];
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 2; i++) exp_q[i].delete();
    end
  endtask

  task automatic idle(input int n);
    logic [1:0] acc;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, acc);
  endtask

  // Writes are idempotent, so re-presenting until both instances took it is safe
  task automatic wr_hold(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [1:0] acc;
    logic [1:0] got;
    got = 2'b00;
    for (int t = 0; t < 16 && got != 2'b11; t++) begin
      step(1'b0, 1'b1, 1'b1, a, s, d, 1'b0, acc);
      got = got | acc;
    end
  endtask

  task automatic rd_once(input logic [31:0] a);
    logic [1:0] acc;
    step(1'b0, 1'b1, 1'b0, a, 4'h0, 32'h0, 1'b0, acc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] acc;

    step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, acc);
    step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, acc);
    checking = 1'b1;
    idle(2);

    // Known contents for the 16 words the rest of the run touches
    for (int w = 0; w < 16; w++) wr_hold(32'(w) << 2, 4'hF, $urandom);
    idle(12);

    // Write then read the same word on the next cycle
    wr_hold(32'h10, 4'hF, 32'h1234_5678);
    rd_once(32'h10);
    idle(12);

    // Byte enables: AABBCCDD merged with 11223344 under 0101 gives AA22CC44
    wr_hold(32'h20, 4'hF, 32'hAABB_CCDD);
    wr_hold(32'h20, 4'b0101, 32'h1122_3344);
    rd_once(32'h20);
    idle(12);

    // Fill the LATENCY=8 queue, then keep requesting while it is full
    for (int k = 0; k < 14; k++) rd_once(32'($urandom_range(0, 15)) << 2);
    idle(12);

    // addr_stall holds off acceptance for three cycles with req high
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, acc);
    rd_once(32'h8);
    idle(12);

    // Reset with reads in flight: nothing comes back, memory survives
    for (int k = 0; k < 3; k++) rd_once(32'(k) << 2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, acc);
    idle(16);
    rd_once(32'h20);
    idle(12);

    // Address wrap: 0x1000 aliases word 0 with AW=10; stream reads
    wr_hold(32'h1000, 4'hF, 32'hCAFE_F00D);
    for (int k = 0; k < 8; k++) rd_once((k % 2 == 0) ? 32'h0 : 32'h1000);
    idle(12);

    // Randomised traffic with occasional stall and reset
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)),
           ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2),
           4'($urandom_range(0, 15)),
           $urandom,
           ($urandom_range(0, 9) == 0),
           acc);
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Slave/responder end of the data-side SRAM-like interface (req/addr_ok/data_ok) consumed by the CPU memory stage.
- Accepts requests on the address handshake, commits writes into a local word memory, and returns exactly one in-order data_ok pulse per accepted request after a fixed latency.
- Used as the data-RAM model in the CPU testbench and as the reference responder when verifying the initiator side.

Parameters:
- LATENCY, 2, cycles from address handshake to data_ok; legal range 1..15.
- DEPTH, 4, max outstanding (accepted, not yet answered) requests; power of 2, >=2.
- AW, 10, word-address width; memory holds 2^AW 32-bit words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req  in  1  request valid
- wr  in  1  1=write, 0=read
- size  in  2  0=byte, 1=half, 2=word; informational only, wstrb governs writes
- addr  in  32  byte address; word index = addr[AW+1:2], upper bits ignored (wraps modulo 2^AW)
- wstrb  in  4  byte enables for writes
- wdata  in  32  write data
- addr_stall  in  1  test hook; forces addr_ok low
- addr_ok  out  1  address handshake accept
- data_ok  out  1  one-cycle response pulse
- rdata  out  32  read data, valid when data_ok

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset state: queue empty (count=0, head/tail pointers 0), all entry countdowns 0.
  - Outputs after reset: addr_ok = !addr_stall; data_ok=0; rdata=0.
  - Memory contents are not reset.
- addr_ok (combinational) = (count < DEPTH) && !addr_stall.
  - A response popping in the same cycle does not free a slot for that cycle's accept.
- Handshake: a request is accepted when req && addr_ok at a rising edge. addr_ok never depends on req.
- On accept (same edge):
  - Write: each byte i of mem[addr[AW+1:2]] with wstrb[i]=1 takes wdata[8i+7:8i].
  - Read: the queue entry captures the current mem word (pre-write contents of that edge; a read and a write cannot be the same request).
  - Entry pushed at tail with countdown = LATENCY-1; count increments.
- Countdown: every valid entry whose countdown is >0 decrements by 1 each cycle.
- Response:
  - data_ok = head valid && head countdown==0.
  - rdata = head data when data_ok (read entries) or 32'h0 (write entries); 0 when data_ok=0.
  - Head pops at the end of any cycle with data_ok=1.
  - No response backpressure: the initiator must take data_ok when it is asserted.
- Latency:
  - Request accepted at edge of cycle t gives data_ok in cycle t+LATENCY.
  - Back-to-back accepts give back-to-back data_ok pulses.
  - Responses are strictly in acceptance order.
- Read-after-write: a read accepted after a write to the same word returns the written data, including the next cycle.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Full: count==DEPTH gives addr_ok=0 until a pop completes. The cycle after the pop, addr_ok=1 (if not stalled).
- Pointer wrap: pointers wrap modulo DEPTH.
- Reset mid-operation: all outstanding responses are discarded (no data_ok after reset). Writes already accepted remain in memory.
- size and misalignment are not checked; no error response.

Test Plan:
- Write-then-read, LATENCY=2:
  - Stimulus: write 0x1234_5678 to addr 0x10 with wstrb=F, accepted cycle 0; read 0x10 accepted cycle 1.
  - Response: data_ok at cycles 2 and 3; rdata=0 at cycle 2, 0x1234_5678 at cycle 3.
- Byte enables:
  - Stimulus: word 0x20 holds 0xAABBCCDD; write wdata=0x11223344 with wstrb=0101; then read 0x20.
  - Response: rdata=0xAA22CC44.
- Full queue, DEPTH=4, LATENCY=8:
  - Stimulus: four reads accepted on cycles 0-3.
  - Response: addr_ok=0 in cycles 4..8; data_ok in cycles 8,9,10,11 in order. addr_ok=1 again in cycle 9.
- addr_stall:
  - Stimulus: req held high, addr_stall high for cycles 0-2.
  - Response: no accept until cycle 3; data_ok at cycle 3+LATENCY.
- Reset mid-flight:
  - Stimulus: three reads outstanding, reset asserted one cycle.
  - Response: count=0; no data_ok for the next 16 cycles; a fresh read after reset returns correct memory contents.
- LATENCY=1 streaming with address wrap:
  - Stimulus: 8 consecutive reads to addr 0x0 and 0x1000 (AW=10).
  - Response: both addresses alias the same word; data_ok in every cycle 1..8.
